// File: rtl/kbd_ctrl_pkg.sv
// Shared types and ASCII key codes for the keyboard-driven playback sequencer.
// Used by kbd_cmd_decode and kbd_playback_ctrl.
package kbd_ctrl_pkg;

    localparam logic [7:0] ASCII_D_UC = 8'h44;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_E_UC = 8'h45;
    localparam logic [7:0] ASCII_E_LC = 8'h65;
    localparam logic [7:0] ASCII_B_UC = 8'h42;
    localparam logic [7:0] ASCII_B_LC = 8'h62;
    localparam logic [7:0] ASCII_F_UC = 8'h46;
    localparam logic [7:0] ASCII_F_LC = 8'h66;
    localparam logic [7:0] ASCII_R_UC = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND_LO,
        SEND_HI,
        ADVANCE
    } ctrl_state_t;

    typedef struct packed {
        logic play;
        logic pause;
        logic fwd;
        logic bwd;
        logic restart;
    } kbd_cmd_t;

    // Exact 8-bit compare against either case; bit 7 set never matches.
    function automatic logic key_match(input logic [7:0] code,
                                       input logic [7:0] uc,
                                       input logic [7:0] lc);
        return (code == uc) || (code == lc);
    endfunction

endpackage

// File: rtl/kbd_cmd_decode.sv
// ASCII key to one-hot command decoder; the flag registers in kbd_playback_ctrl
// capture its output on the same edge that samples kbd_valid.
module kbd_cmd_decode
    import kbd_ctrl_pkg::*;
(
    input  logic [7:0] kbd_data_i,
    input  logic       kbd_valid_i,
    output kbd_cmd_t   cmd_o
);

    always_comb begin
        cmd_o = '0;
        if (kbd_valid_i) begin
            cmd_o.play    = key_match(kbd_data_i, ASCII_E_UC, ASCII_E_LC);
            cmd_o.pause   = key_match(kbd_data_i, ASCII_D_UC, ASCII_D_LC);
            cmd_o.fwd     = key_match(kbd_data_i, ASCII_F_UC, ASCII_F_LC);
            cmd_o.bwd     = key_match(kbd_data_i, ASCII_B_UC, ASCII_B_LC);
            cmd_o.restart = key_match(kbd_data_i, ASCII_R_UC, ASCII_R_LC);
        end
    end

endmodule

// File: rtl/kbd_playback_ctrl.sv
// Keyboard-driven playback sequencer: fetches 32-bit flash words and paces out 16-bit halves.
// Define KBD_PLAYBACK_LOOP_EN to wrap at the ends of the sample region instead of stopping.
module kbd_playback_ctrl
    import kbd_ctrl_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 23,
    parameter logic [ADDR_W-1:0]   ADDR_MAX = ADDR_W'(23'h7FFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        kbd_data,
    input  logic              kbd_valid,
    input  logic              sample_tick,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic              playing,
    output logic              dir_fwd
);

`ifdef KBD_PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    kbd_cmd_t cmd;

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]       word_q, word_d;
    logic [15:0]       audio_out_q, audio_out_d;
    logic              audio_valid_q, audio_valid_d;
    logic              playing_q, playing_d;
    logic              dir_fwd_q, dir_fwd_d;
    logic              restart_q, restart_d;
    logic              half_done_q, half_done_d;
    logic              send_ok;

    kbd_cmd_decode u_decode (
        .kbd_data_i  (kbd_data),
        .kbd_valid_i (kbd_valid),
        .cmd_o       (cmd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            word_q        <= '0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
            playing_q     <= 1'b0;
            dir_fwd_q     <= 1'b1;
            restart_q     <= 1'b0;
            half_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            word_q        <= word_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
            playing_q     <= playing_d;
            dir_fwd_q     <= dir_fwd_d;
            restart_q     <= restart_d;
            half_done_q   <= half_done_d;
        end
    end

    // All decisions use the registered flags; key presses land on top so a key
    // arriving on the same edge as an FSM update to a flag wins.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        word_d        = word_q;
        audio_out_d   = audio_out_q;
        audio_valid_d = 1'b0;
        playing_d     = playing_q;
        dir_fwd_d     = dir_fwd_q;
        restart_d     = restart_q;
        half_done_d   = half_done_q;
        send_ok       = sample_tick && playing_q;

        case (state_q)
            IDLE: begin
                if (restart_q) begin
                    rd_addr_d = dir_fwd_q ? '0 : ADDR_MAX;
                    restart_d = 1'b0;
                end
                if (playing_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    word_d      = rd_data;
                    half_done_d = 1'b0;
                    if (restart_q) begin
                        state_d = ADVANCE;
                    end else begin
                        state_d = dir_fwd_q ? SEND_LO : SEND_HI;
                    end
                end
            end
            // half_done tracks whether the other half already went out, so a
            // direction change mid-word still emits the remaining half once.
            SEND_LO: begin
                if (restart_q) begin
                    state_d = ADVANCE;
                end else if (send_ok) begin
                    audio_out_d   = word_q[15:0];
                    audio_valid_d = 1'b1;
                    if (half_done_q) begin
                        state_d = ADVANCE;
                    end else begin
                        half_done_d = 1'b1;
                        state_d     = SEND_HI;
                    end
                end
            end
            SEND_HI: begin
                if (restart_q) begin
                    state_d = ADVANCE;
                end else if (send_ok) begin
                    audio_out_d   = word_q[31:16];
                    audio_valid_d = 1'b1;
                    if (half_done_q) begin
                        state_d = ADVANCE;
                    end else begin
                        half_done_d = 1'b1;
                        state_d     = SEND_LO;
                    end
                end
            end
            ADVANCE: begin
                state_d = playing_q ? REQ : IDLE;
                if (restart_q) begin
                    rd_addr_d = dir_fwd_q ? '0 : ADDR_MAX;
                    restart_d = 1'b0;
                end else if (dir_fwd_q) begin
                    if (rd_addr_q == ADDR_MAX) begin
                        rd_addr_d = '0;
                        if (!LOOP_EN) begin
                            playing_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end else begin
                    if (rd_addr_q == '0) begin
                        rd_addr_d = ADDR_MAX;
                        if (!LOOP_EN) begin
                            playing_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q - ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmd.play)    playing_d = 1'b1;
        if (cmd.pause)   playing_d = 1'b0;
        if (cmd.fwd)     dir_fwd_d = 1'b1;
        if (cmd.bwd)     dir_fwd_d = 1'b0;
        if (cmd.restart) restart_d = 1'b1;
    end

    assign rd_req      = (state_q == REQ);
    assign rd_addr     = rd_addr_q;
    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;
    assign playing     = playing_q;
    assign dir_fwd     = dir_fwd_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Self-checking bench for kbd_playback_ctrl: key-decode vector table, scoreboarded audio
// samples and hand-written sequences for handshake, restart, end-of-region and reset cases.
module tb_kbd_playback_ctrl;

    localparam logic [22:0] ADDR_MAX = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic        sample_tick;
    logic        rd_req;
    logic        rd_ack;
    logic [22:0] rd_addr;
    logic [31:0] rd_data;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        playing;
    logic        dir_fwd;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] expQ[$];

    typedef struct {
        logic [7:0] code;
        logic       expPlaying;
        logic       expDirFwd;
    } key_vec_t;

    key_vec_t keyTable[13];

    kbd_playback_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .kbd_data    (kbd_data),
        .kbd_valid   (kbd_valid),
        .sample_tick (sample_tick),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .playing     (playing),
        .dir_fwd     (dir_fwd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        kbd_data  = code;
        kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    task automatic sendTick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic flashAck(input logic [31:0] data);
        rd_data = data;
        rd_ack  = 1'b1;
        @(negedge clk);
        rd_ack  = 1'b0;
    endtask

    task automatic waitReq(input string name);
        for (int i = 0; i < 20 && !rd_req; i++) @(negedge clk);
        checkOutput(name, 32'(rd_req), 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every audio_valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (!reset && audio_valid) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL audio_unexpected: got 0x%0h, expected no sample", audio_out);
            end else begin
                logic [15:0] exp;
                exp = expQ.pop_front();
                if (audio_out !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL audio_sample: got 0x%0h, expected 0x%0h", audio_out, exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        keyTable[0]  = '{8'h41, 1'b0, 1'b1};
        keyTable[1]  = '{8'h42, 1'b0, 1'b0};
        keyTable[2]  = '{8'h47, 1'b0, 1'b0};
        keyTable[3]  = '{8'h66, 1'b0, 1'b1};
        keyTable[4]  = '{8'h30, 1'b0, 1'b1};
        keyTable[5]  = '{8'h62, 1'b0, 1'b0};
        keyTable[6]  = '{8'h46, 1'b0, 1'b1};
        keyTable[7]  = '{8'h45, 1'b1, 1'b1};
        keyTable[8]  = '{8'hE4, 1'b1, 1'b1};
        keyTable[9]  = '{8'h64, 1'b0, 1'b1};
        keyTable[10] = '{8'h65, 1'b1, 1'b1};
        keyTable[11] = '{8'h44, 1'b0, 1'b1};
        keyTable[12] = '{8'h65, 1'b1, 1'b1};

        reset       = 1'b1;
        kbd_data    = 8'h00;
        kbd_valid   = 1'b0;
        sample_tick = 1'b0;
        rd_ack      = 1'b0;
        rd_data     = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_rd_req", 32'(rd_req), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("reset_audio_out", 32'(audio_out), 32'd0);
        checkOutput("reset_audio_valid", 32'(audio_valid), 32'd0);
        checkOutput("reset_playing", 32'(playing), 32'd0);
        checkOutput("reset_dir_fwd", 32'(dir_fwd), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(keyTable[i].code);
            checkOutput($sformatf("key_%0h_playing", keyTable[i].code),
                        32'(playing), 32'(keyTable[i].expPlaying));
            checkOutput($sformatf("key_%0h_dir_fwd", keyTable[i].code),
                        32'(dir_fwd), 32'(keyTable[i].expDirFwd));
        end

        // Asynchronous reset in the middle of an unacknowledged request.
        waitReq("pre_reset_req");
        #1 reset = 1'b1;
        #1;
        checkOutput("async_rd_req", 32'(rd_req), 32'd0);
        checkOutput("async_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("async_audio_valid", 32'(audio_valid), 32'd0);
        checkOutput("async_playing", 32'(playing), 32'd0);
        checkOutput("async_dir_fwd", 32'(dir_fwd), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", 32'(rd_req), 32'd0);

        // Basic forward playback of one word.
        applyStimulus(8'h65);
        checkOutput("play_latency", 32'(playing), 32'd1);
        waitReq("first_req");
        checkOutput("first_addr", 32'(rd_addr), 32'd0);
        expQ.push_back(16'h5555);
        expQ.push_back(16'hAAAA);
        flashAck(32'hAAAA5555);
        sendTick();
        sendTick();
        waitReq("second_req");
        checkOutput("second_addr", 32'(rd_addr), 32'd1);

        // Direction change mid-word, then running off the low end.
        expQ.push_back(16'h1111);
        flashAck(32'h22221111);
        sendTick();
        applyStimulus(8'h42);
        checkOutput("bwd_flag", 32'(dir_fwd), 32'd0);
        expQ.push_back(16'h2222);
        sendTick();
        waitReq("bwd_req0");
        checkOutput("bwd_addr0", 32'(rd_addr), 32'd0);
        expQ.push_back(16'h4444);
        expQ.push_back(16'h3333);
        flashAck(32'h44443333);
        sendTick();
        sendTick();
`ifdef KBD_PLAYBACK_LOOP_EN
        waitReq("wrap_req");
        checkOutput("wrap_addr", 32'(rd_addr), 32'(ADDR_MAX));
        checkOutput("wrap_playing", 32'(playing), 32'd1);
`else
        for (int i = 0; i < 20 && playing; i++) @(negedge clk);
        checkOutput("stop_playing", 32'(playing), 32'd0);
        checkOutput("stop_addr", 32'(rd_addr), 32'(ADDR_MAX));
        repeat (2) @(negedge clk);
        checkOutput("stop_no_req", 32'(rd_req), 32'd0);
`endif
        applyStimulus(8'h65);
        waitReq("replay_req");
        checkOutput("replay_addr", 32'(rd_addr), 32'(ADDR_MAX));
        doReset();

        // Pause during a request whose ack is delayed.
        applyStimulus(8'h45);
        waitReq("pause_req");
        applyStimulus(8'h44);
        checkOutput("pause_flag", 32'(playing), 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("held_rd_req", 32'(rd_req), 32'd1);
            checkOutput("held_rd_addr", 32'(rd_addr), 32'd0);
            @(negedge clk);
        end
        flashAck(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            sendTick();
            checkOutput("paused_tick", 32'(audio_valid), 32'd0);
        end
        expQ.push_back(16'h5678);
        expQ.push_back(16'h1234);
        applyStimulus(8'h65);
        sendTick();
        sendTick();

        // Stream forward to word 0x1234.
        for (int a = 1; a < 32'h1234; a++) begin
            logic [31:0] av;
            av = a;
            waitReq("stream_req");
            checkOutput("stream_addr", 32'(rd_addr), av);
            expQ.push_back(av[15:0]);
            expQ.push_back(av[15:0] ^ 16'hA5A5);
            flashAck({av[15:0] ^ 16'hA5A5, av[15:0]});
            sendTick();
            sendTick();
        end

        // Restart during SEND_LO forward: HI half skipped, next address 0.
        waitReq("r_fwd_req");
        checkOutput("r_fwd_at", 32'(rd_addr), 32'h1234);
        expQ.push_back(16'hBEEF);
        flashAck(32'hDEADBEEF);
        sendTick();
        applyStimulus(8'h52);
        sendTick();
        waitReq("r_fwd_next_req");
        checkOutput("r_fwd_addr", 32'(rd_addr), 32'd0);

        // Restart while backward: next address is ADDR_MAX.
        expQ.push_back(16'h0001);
        flashAck(32'h00020001);
        sendTick();
        applyStimulus(8'h62);
        applyStimulus(8'h72);
        sendTick();
        waitReq("r_bwd_req");
        checkOutput("r_bwd_addr", 32'(rd_addr), 32'(ADDR_MAX));

        // Key and tick on the same edge: tick uses the old (playing) flag.
        expQ.push_back(16'h0BBB);
        flashAck(32'h0BBB0AAA);
        kbd_data    = 8'h44;
        kbd_valid   = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        kbd_valid   = 1'b0;
        sample_tick = 1'b0;
        checkOutput("same_edge_pause", 32'(playing), 32'd0);
        sendTick();
        checkOutput("same_edge_no_audio", 32'(audio_valid), 32'd0);
        expQ.push_back(16'h0AAA);
        applyStimulus(8'h45);
        sendTick();
        waitReq("bwd_step_req");
        checkOutput("bwd_step_addr", 32'(rd_addr), 32'(ADDR_MAX - 23'd1));

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
